// File: rtl/mul_div_unit_pkg.sv
// Shared op codes, FSM states and op-decoding helpers for the multiply/divide unit.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic op_is_signed(op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// Combinational sign handling: operand magnitudes at capture, result sign restoration at FIX.
module mul_div_unit_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [WIDTH-1:0]   a_mag,
  output logic [WIDTH-1:0]   b_mag,
  input  logic [2*WIDTH-1:0] acc,
  input  logic               neg_res,
  input  logic               neg_rem,
  output logic [2*WIDTH-1:0] prod_fix,
  output logic [WIDTH-1:0]   quot_fix,
  output logic [WIDTH-1:0]   rem_fix
);

  // The most negative value maps onto itself, which reads correctly as an unsigned magnitude.
  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  assign prod_fix = neg_res ? -acc : acc;
  assign quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; one result bit per CALC cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state;
  op_e                op_r;
  op_e                op_in;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   raw_a;
  logic               neg_res;
  logic               neg_rem;
  logic               div0;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   hi_fin;
  logic [WIDTH-1:0]   lo_fin;

  assign op_in = op_e'(op);

  mul_div_unit_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .a         (in1),
    .b         (in2),
    .is_signed (op_is_signed(op_in)),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .acc       (acc),
    .neg_res   (neg_res),
    .neg_rem   (neg_rem),
    .prod_fix  (prod_fix),
    .quot_fix  (quot_fix),
    .rem_fix   (rem_fix)
  );

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  assign addend  = acc[0] ? opnd : '0;
  assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign trial   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};

  always_comb begin
    acc_next = acc;
    if (op_is_div(op_r)) begin
      if (!trial[WIDTH]) acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else               acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    hi_fin = prod_fix[2*WIDTH-1:WIDTH];
    lo_fin = prod_fix[WIDTH-1:0];
    if (op_is_div(op_r)) begin
      hi_fin = div0 ? raw_a : rem_fix;
      lo_fin = div0 ? '1 : quot_fix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_r    <= OP_MULT;
      count   <= '0;
      acc     <= '0;
      opnd    <= '0;
      raw_a   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_CALC;
            busy    <= 1'b1;
            count   <= '0;
            op_r    <= op_in;
            raw_a   <= in1;
            div0    <= (in2 == '0);
            neg_res <= op_is_signed(op_in) && (in1[WIDTH-1] ^ in2[WIDTH-1]);
            neg_rem <= op_is_signed(op_in) && in1[WIDTH-1];
            if (op_is_div(op_in)) begin
              acc  <= {{WIDTH{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{WIDTH{1'b0}}, b_mag};
              opnd <= a_mag;
            end
          end else begin
            if (wr_hi) hi <= in1;
            if (wr_lo) lo <= in1;
          end
        end
        S_CALC: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          if (count == LAST) state <= S_FIX;
        end
        S_FIX: begin
          state <= S_DONE;
          done  <= 1'b1;
          hi    <= hi_fin;
          lo    <= lo_fin;
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
